// File: rtl/env_pkg.sv
// rtl/env_pkg.sv - shared types, constants and saturating add for the ADSR envelope
package env_pkg;

  localparam int QW = 32;
  localparam logic [QW-1:0] PEAK = 32'h0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

  typedef enum logic [1:0] {
    PH_ENTER = 2'd0,
    PH_LOAD  = 2'd1,
    PH_RAMP  = 2'd2
  } phase_e;

  // Unsigned level plus signed slope, clamped to 0..PEAK.
  function automatic logic [QW-1:0] sat_add(input logic [QW-1:0] level,
                                            input logic [QW-1:0] slope);
    logic signed [QW+1:0] sum;
    sum = $signed({2'b00, level}) + $signed({{2{slope[QW-1]}}, slope});
    if (sum[QW+1]) return '0;
    else if (sum > $signed({2'b00, PEAK})) return PEAK;
    else return sum[QW-1:0];
  endfunction

endpackage

// File: rtl/env_level_acc.sv
// rtl/env_level_acc.sv - saturating 16Q.16 level accumulator with target-overshoot detect
module env_level_acc
  import env_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ce_i,
  input  logic          step_i,
  input  logic          last_i,
  input  logic          load_i,
  input  logic [QW-1:0] load_val_i,
  input  logic [QW-1:0] target_i,
  input  logic [QW-1:0] slope_i,
  output logic [QW-1:0] level_o,
  output logic          done_o
);

  logic [QW-1:0] level_q, level_d, sum;
  logic          passed;

  always_comb begin
    sum    = sat_add(level_q, slope_i);
    passed = 1'b0;
    if (slope_i[QW-1])        passed = (sum < target_i);
    else if (slope_i != '0)   passed = (sum > target_i);
    done_o  = step_i & (last_i | passed);
    level_d = level_q;
    if (load_i)      level_d = load_val_i;
    else if (step_i) level_d = done_o ? target_i : sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   level_q <= '0;
    else if (ce_i) level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: rtl/env_adsr_ramp.sv
// rtl/env_adsr_ramp.sv - ADSR sequencer: drives Rise/Run to the slope divider, integrates Slope into Level
module env_adsr_ramp
  import env_pkg::*;
#(
  parameter int SLOPE_LAT = 40
) (
  input  logic          Sys_clk_i,
  input  logic          Env_rst_n_i,
  input  logic          Env_ce_i,
  input  logic          Sample_tick_i,
  input  logic          Gate_i,
  input  logic [QW-1:0] Attack_len_i,
  input  logic [QW-1:0] Decay_len_i,
  input  logic [QW-1:0] Release_len_i,
  input  logic [QW-1:0] Sustain_lvl_i,
  output logic [QW-1:0] Rise_o,
  output logic [QW-1:0] Run_o,
  input  logic [QW-1:0] Slope_i,
  output logic [QW-1:0] Level_o,
  output logic [2:0]    Stage_o,
  output logic          Busy_o
);

  localparam int SW = (SLOPE_LAT < 2) ? 1 : $clog2(SLOPE_LAT);
  localparam logic [SW-1:0] SETTLE_END = SW'(SLOPE_LAT - 1);

  stage_e        stage_q, nxt_stage;
  phase_e        phase_q;
  logic          gate_q, gate_qq, busy_q;
  logic [SW-1:0] settle_q;
  logic [QW-1:0] cnt_q, rise_q, run_q;

  logic [QW-1:0] sus_clamped, stage_len, stage_tgt, level_w, acc_val;
  logic          gate_rise, fall_evt, is_ramp, step, acc_load, acc_done;

  assign sus_clamped = (Sustain_lvl_i > PEAK) ? PEAK : Sustain_lvl_i;
  assign gate_rise   = gate_q & ~gate_qq;
  assign fall_evt    = ~gate_q & gate_qq &
                       (stage_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN});

  always_comb begin
    stage_len = '0;
    stage_tgt = '0;
    nxt_stage = ST_IDLE;
    is_ramp   = 1'b1;
    case (stage_q)
      ST_ATTACK:  begin stage_len = Attack_len_i;  stage_tgt = PEAK;        nxt_stage = ST_DECAY;   end
      ST_DECAY:   begin stage_len = Decay_len_i;   stage_tgt = sus_clamped; nxt_stage = ST_SUSTAIN; end
      ST_RELEASE: begin stage_len = Release_len_i; stage_tgt = '0;          nxt_stage = ST_IDLE;    end
      ST_SUSTAIN: begin is_ramp = 1'b0; nxt_stage = ST_SUSTAIN; end
      default:    is_ramp = 1'b0;
    endcase
  end

  // Gate events pre-empt the tick so a retrigger never sees a half-applied stage end.
  always_comb begin
    step     = Sample_tick_i & (phase_q == PH_RAMP) & is_ramp & ~gate_rise & ~fall_evt;
    acc_load = 1'b0;
    acc_val  = stage_tgt;
    if (!gate_rise && !fall_evt) begin
      if (phase_q == PH_ENTER && is_ramp && stage_len == '0) begin
        acc_load = 1'b1;
      end else if (stage_q == ST_SUSTAIN && Sample_tick_i) begin
        acc_load = 1'b1;
        acc_val  = sus_clamped;
      end
    end
  end

  env_level_acc u_acc (
    .clk_i      (Sys_clk_i),
    .rst_ni     (Env_rst_n_i),
    .ce_i       (Env_ce_i),
    .step_i     (step),
    .last_i     (cnt_q == 32'd1),
    .load_i     (acc_load),
    .load_val_i (acc_val),
    .target_i   (stage_tgt),
    .slope_i    (Slope_i),
    .level_o    (level_w),
    .done_o     (acc_done)
  );

  always_ff @(posedge Sys_clk_i or negedge Env_rst_n_i) begin
    if (!Env_rst_n_i) begin
      gate_q   <= 1'b0;
      gate_qq  <= 1'b0;
      stage_q  <= ST_IDLE;
      phase_q  <= PH_ENTER;
      busy_q   <= 1'b0;
      settle_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      run_q    <= 32'd1;
    end else if (Env_ce_i) begin
      gate_q  <= Gate_i;
      gate_qq <= gate_q;
      if (gate_rise) begin
        stage_q <= ST_ATTACK;
        phase_q <= PH_ENTER;
        busy_q  <= 1'b1;
      end else if (fall_evt) begin
        stage_q <= ST_RELEASE;
        phase_q <= PH_ENTER;
        busy_q  <= 1'b1;
      end else begin
        case (phase_q)
          PH_ENTER: begin
            if (is_ramp) begin
              if (stage_len == '0) begin
                stage_q <= nxt_stage;
                busy_q  <= (nxt_stage != ST_IDLE);
              end else begin
                rise_q   <= stage_tgt - level_w;
                run_q    <= stage_len;
                cnt_q    <= stage_len;
                settle_q <= '0;
                phase_q  <= PH_LOAD;
              end
            end
          end
          PH_LOAD: begin
            if (settle_q == SETTLE_END) phase_q  <= PH_RAMP;
            else                        settle_q <= settle_q + 1'b1;
          end
          PH_RAMP: begin
            if (step) cnt_q <= cnt_q - 32'd1;
            if (acc_done) begin
              stage_q <= nxt_stage;
              phase_q <= PH_ENTER;
              busy_q  <= (nxt_stage != ST_IDLE);
            end
          end
          default: phase_q <= PH_ENTER;
        endcase
      end
    end
  end

  assign Rise_o  = rise_q;
  assign Run_o   = run_q;
  assign Level_o = level_w;
  assign Stage_o = stage_q;
  assign Busy_o  = busy_q;

endmodule
